instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and issues word-aligned reads to instruction memory over a request/grant/response handshake. Returned words are buffered in a small FIFO and presented to the decoder as a valid/ready stream of `{instr_pc, instr_out}`. A taken branch from the execute stage redirects the PC, flushes the buffer and squashes any in-flight read.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: instruction buffer entries; legal range 2..4.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: read request; held high until `imem_gnt`.
- `imem_addr` out 32: read byte address; bits [1:0] are always 0.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid; one response per grant, in order.
- `imem_rdata` in 32: instruction word.
- `branch_taken` in 1: redirect strobe, one cycle.
- `branch_target` in 32: redirect address; bits [1:0] are forced to 0 internally.
- `instr_valid` out 1: buffer head valid.
- `instr_ready` in 1: decoder accepts the head.
- `instr_out` out 32: instruction word to the decoder.
- `instr_pc` out 32: PC of `instr_out`.
- `fetch_count` out 32: count of delivered instructions (see Configuration).

## Operation
- FSM states:
  - `REQ`: `imem_req`=1 when credit is available.
  - `WAIT`: one read granted, awaiting `imem_rvalid`.
  - `DROP`: a squashed read is still outstanding; its response is discarded.
- At most one read is outstanding at any time.
- Credit rule: issue a request only when `count + outstanding < FIFO_DEPTH`. This guarantees the buffer never overflows.
- `REQ` to `WAIT` on `imem_gnt`. The PC advances by 4 in the same cycle, wrapping 0xFFFF_FFFC to 0x0000_0000.
- `WAIT` to `REQ` on `imem_rvalid`. `{pc_of_request, imem_rdata}` is pushed to the FIFO.
- `DROP` to `REQ` on `imem_rvalid`. Nothing is pushed.
- Output stream:
  - `instr_valid` = FIFO not empty; `instr_out`/`instr_pc` = FIFO head.
  - Pop on `instr_valid & instr_ready`.
  - `instr_out`/`instr_pc` hold their values while `instr_valid & ~instr_ready`.
- Redirect (`branch_taken`=1) has highest priority:
  - PC is set to `{branch_target[31:2],2'b00}` and the FIFO is flushed (count=0).
  - A pop in the same cycle is discarded.
  - State after redirect:
    - `WAIT`, or `REQ` with `imem_gnt` in the same cycle: go to `DROP`.
    - `REQ` with no grant: stay in `REQ` with the new address. Changing `imem_addr` while ungranted is allowed only on redirect.
    - `DROP`: stay in `DROP`.
  - `imem_rvalid` in the same cycle as a redirect is discarded, and the FSM goes to `REQ`.
- Simultaneous push and pop: both occur, and count is unchanged.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `fetch_count`=0.
  - FSM=`REQ`, FIFO empty.
- Reset may assert mid-operation. All state clears immediately. An outstanding memory response arriving after reset release is not tracked; the memory side is reset together with this block.
- `imem_req` first asserts in the first cycle after `rst_n` deasserts.
- Fetch latency: grant in cycle N, earliest `imem_rvalid` in N+1, `instr_valid` in N+2 (the FIFO is registered).
- Redirect in cycle N:
  - `instr_valid`=0 in N+1.
  - If not in `DROP`, `imem_req` with the target address in N+1.
- Throughput: one instruction every 2 cycles with zero-wait memory. This is a consequence of the single outstanding read.
- No combinational path from `instr_ready` or `branch_taken` to `imem_req`/`imem_addr`. Both are registered.

## Configuration
- Macro: `IFETCH_PERF_CNT_EN`.
- Defined: `fetch_count` increments by 1 on every pop (`instr_valid & instr_ready`) not coinciding with `branch_taken`. It wraps at 2^32 and is cleared only by reset.
- Undefined: `fetch_count` is tied to 0 and no counter register is built.

## Test plan
- **Reset and sequential fetch:** release reset, memory grants immediately with `rdata`=addr+0x100, `instr_ready`=1 → `imem_addr` sequence 0x0, 0x4, 0x8; stream delivers (pc 0x0, 0x100), (pc 0x4, 0x104) in order.
- **Back-pressure:** `instr_ready`=0 for 10 cycles → FIFO fills to `FIFO_DEPTH` (2), `imem_req` stays 0 after 2 fetches, and the head holds pc 0x0 stable.
- **Redirect during `WAIT`:** redirect to 0x203 (forced to 0x200) while a read of 0x8 is outstanding → `instr_valid`=0 next cycle; the 0x8 response is dropped; next `imem_addr`=0x200 and next delivered pc=0x200.
- **Redirect with simultaneous `rvalid` and pop:** no stale word is delivered, and `fetch_count` does not increment in that cycle.
- **PC wrap:** `RESET_PC`=0xFFFF_FFFC → addresses 0xFFFF_FFFC then 0x0000_0000.
- **Async reset mid-fetch:** assert `rst_n`=0 while in `WAIT` → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one read at a time to imem and buffers words for the decoder.
// Optional build macro IFETCH_PERF_CNT_EN enables the fetch_count delivered-instruction counter.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] fetch_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_req_pc;
    logic           r_imem_req;
    logic [31:0]    r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]    r_fifo_instr [FIFO_DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;

    state_t         w_state_nxt;
    logic [CW-1:0]  w_count_nxt;
    logic           w_gnt;
    logic           w_push;
    logic           w_pop;
    logic [31:0]    w_target;
    logic [PW-1:0]  w_rd_ptr_inc;
    logic [PW-1:0]  w_wr_ptr_inc;

    always_comb begin
        w_gnt        = r_imem_req & imem_gnt;
        w_pop        = (r_count != '0) & instr_ready;
        w_push       = (r_state == S_WAIT) & imem_rvalid & ~branch_taken;
        w_target     = branch_target & 32'hFFFF_FFFC;
        w_rd_ptr_inc = (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
        w_wr_ptr_inc = (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);

        // A response arriving with a redirect closes the read; otherwise the redirect squashes it.
        w_state_nxt = r_state;
        case (r_state)
            S_REQ:   if (w_gnt) w_state_nxt = branch_taken ? S_DROP : S_WAIT;
            S_WAIT:  if (imem_rvalid) w_state_nxt = S_REQ;
                     else if (branch_taken) w_state_nxt = S_DROP;
            S_DROP:  if (imem_rvalid) w_state_nxt = S_REQ;
            default: w_state_nxt = S_REQ;
        endcase

        if (branch_taken) w_count_nxt = '0;
        else              w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_req_pc     <= '0;
            r_imem_req   <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_fifo_pc    <= '{default: '0};
            r_fifo_instr <= '{default: '0};
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            // Outstanding is zero whenever the next state is REQ, so credit reduces to the count.
            r_imem_req <= (w_state_nxt == S_REQ) && (w_count_nxt < CW'(FIFO_DEPTH));

            if (branch_taken)  r_pc <= w_target;
            else if (w_gnt)    r_pc <= r_pc + 32'd4;
            if (w_gnt)         r_req_pc <= r_pc;

            if (branch_taken) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]    <= r_req_pc;
                    r_fifo_instr[r_wr_ptr] <= imem_rdata;
                    r_wr_ptr               <= w_wr_ptr_inc;
                end
                if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr_out   = r_fifo_instr[r_rd_ptr];
    assign instr_pc    = r_fifo_pc[r_rd_ptr];

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_fetch_count <= '0;
        else if (w_pop & ~branch_taken) r_fetch_count <= r_fetch_count + 32'd1;
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random memory/decoder/redirect stimulus against a program-order model.
module tb_instr_fetch;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid, branch_taken, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, branch_target, instr_out, instr_pc, fetch_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;

    // Reference model: expected stream, next program-order fetch address, single outstanding read.
    item_t       exp_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] dlv_log[$];
    bit          outst, stale;
    logic [31:0] pend_pc, nf_pc;
    int unsigned since_rst, exp_fc;

    // Memory / decoder driver state.
    bit          pend, prev_req;
    logic [31:0] pend_addr, prev_addr;
    int unsigned pend_dly;
    int unsigned gnt_pct, rdy_pct, br_pct, dly_min, dly_max;

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic expire(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event t=%0t", nm, $time);
    endtask

    task automatic check_q(input string nm, input logic [31:0] q[$], input int unsigned idx,
                           input logic [31:0] exp);
        if (idx < q.size()) check(nm, q[idx], exp);
        else                expire(nm);
    endtask

    // Monitor: compares the decoder-facing stream and request behaviour, pops on acceptance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
`ifdef IFETCH_PERF_CNT_EN
            check("fetch_count", fetch_count, exp_fc);
`else
            check("fetch_count", fetch_count, 32'd0);
`endif
            check("imem_req", 32'(imem_req),
                  32'((since_rst != 0) && !outst && (exp_q.size() < DEPTH)));
            if (imem_req) check("imem_addr", imem_addr, nf_pc);
            check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (instr_valid && exp_q.size() != 0) begin
                check("instr_pc", instr_pc, exp_q[0].pc);
                check("instr_out", instr_out, exp_q[0].ins);
                if (instr_ready && !branch_taken) begin
                    dlv_log.push_back(instr_pc);
                    exp_q.delete(0);
                    exp_fc++;
                end
            end
        end
    end

    // Model update: applies this cycle's redirect, response and grant after the monitor has compared.
    always begin
        @(negedge clk);
        #1;
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            outst     = 1'b0;
            stale     = 1'b0;
            nf_pc     = RST_PC;
            since_rst = 0;
            exp_fc    = 0;
        end else begin
            since_rst++;
            if (branch_taken) begin
                exp_q.delete();
                nf_pc = branch_target & 32'hFFFF_FFFC;
                if (imem_req && imem_gnt) begin
                    gnt_log.push_back(imem_addr);
                    outst = 1'b1;
                    stale = 1'b1;
                end else if (outst && imem_rvalid) begin
                    outst = 1'b0;
                end else if (outst) begin
                    stale = 1'b1;
                end
            end else begin
                if (outst && imem_rvalid) begin
                    if (!stale) exp_q.push_back('{pc: pend_pc, ins: pend_pc + 32'h100});
                    outst = 1'b0;
                end
                if (imem_req && imem_gnt) begin
                    gnt_log.push_back(imem_addr);
                    outst   = 1'b1;
                    stale   = 1'b0;
                    pend_pc = nf_pc;
                    nf_pc   = nf_pc + 32'd4;
                end
            end
        end
    end

    // One cycle of stimulus, applied 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (imem_rvalid) pend = 1'b0;
        if (prev_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = prev_addr;
            pend_dly  = $urandom_range(dly_max, dly_min);
        end
        imem_rvalid = 1'b0;
        if (pend) begin
            if (pend_dly == 0) imem_rvalid = 1'b1;
            else               pend_dly--;
        end
        imem_rdata    = imem_rvalid ? pend_addr + 32'h100 : $urandom();
        imem_gnt      = imem_req && ($urandom_range(99) < gnt_pct);
        instr_ready   = $urandom_range(99) < rdy_pct;
        branch_taken  = $urandom_range(99) < br_pct;
        branch_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                 : $urandom();
        prev_req  = imem_req;
        prev_addr = imem_addr;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        branch_taken = 1'b0;
        instr_ready  = 1'b0;
        pend         = 1'b0;
        prev_req     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        gnt_log.delete();
        dlv_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(imem_req), 32'd0);
        check({tag, "_addr"},  imem_addr, RST_PC);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_out"},   instr_out, 32'd0);
        check({tag, "_pc"},    instr_pc, 32'd0);
        check({tag, "_fcnt"},  fetch_count, 32'd0);
    endtask

    initial begin
        int unsigned n, gi, di;
        logic [31:0] fcb;
        gnt_pct = 100; rdy_pct = 100; br_pct = 0; dly_min = 0; dly_max = 0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        branch_taken = 1'b0; branch_target = '0; instr_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_values("rst");

        // Sequential fetch.
        do_reset();
        repeat (12) tick();
        check_q("seq_addr0", gnt_log, 0, 32'h0);
        check_q("seq_addr1", gnt_log, 1, 32'h4);
        check_q("seq_addr2", gnt_log, 2, 32'h8);
        check_q("seq_pc0", dlv_log, 0, 32'h0);
        check_q("seq_pc1", dlv_log, 1, 32'h4);

        // Back-pressure fills the buffer and stalls requests.
        do_reset();
        rdy_pct = 0;
        repeat (12) tick();
        check("bp_gnt_count", 32'(gnt_log.size()), 32'(DEPTH));
        check("bp_req", 32'(imem_req), 32'd0);
        check("bp_valid", 32'(instr_valid), 32'd1);
        check("bp_head_pc", instr_pc, 32'h0);
        check("bp_head_instr", instr_out, 32'h100);

        // Redirect while the read of 0x8 is outstanding.
        do_reset();
        rdy_pct = 100; dly_min = 3; dly_max = 3;
        n = 0;
        while (gnt_log.size() < 3 && n < 60) begin tick(); n++; end
        check_q("w_gnt_addr", gnt_log, 2, 32'h8);
        branch_taken = 1'b1; branch_target = 32'h203; imem_gnt = 1'b0;
        tick();
        check("w_valid_after_br", 32'(instr_valid), 32'd0);
        gi = gnt_log.size(); di = dlv_log.size();
        repeat (20) tick();
        check_q("w_next_addr", gnt_log, gi, 32'h200);
        check_q("w_next_pc", dlv_log, di, 32'h200);

        // Redirect coinciding with a response and a pop.
        do_reset();
        rdy_pct = 0; dly_min = 1; dly_max = 1;
        n = 0;
        tick();
        while (!(imem_rvalid && instr_valid) && n < 60) begin tick(); n++; end
        if (!(imem_rvalid && instr_valid)) expire("rv_setup");
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h340; imem_gnt = 1'b0;
        fcb = fetch_count;
        tick();
        check("rv_valid_after_br", 32'(instr_valid), 32'd0);
        check("rv_fcnt_hold", fetch_count, fcb);
        rdy_pct = 100; dly_min = 0; dly_max = 0;
        di = dlv_log.size();
        repeat (15) tick();
        check_q("rv_next_pc", dlv_log, di, 32'h340);

        // PC wrap via redirect to the top word (low bits masked).
        do_reset();
        repeat (3) tick();
        imem_gnt = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick();
        gi = gnt_log.size(); di = dlv_log.size();
        repeat (12) tick();
        check_q("wrap_addr0", gnt_log, gi, 32'hFFFF_FFFC);
        check_q("wrap_addr1", gnt_log, gi + 1, 32'h0);
        check_q("wrap_pc0", dlv_log, di, 32'hFFFF_FFFC);
        check_q("wrap_pc1", dlv_log, di + 1, 32'h0);

        // Random traffic.
        do_reset();
        gnt_pct = 60; rdy_pct = 60; br_pct = 4; dly_min = 0; dly_max = 2;
        repeat (3000) tick();
        br_pct = 0; rdy_pct = 100; gnt_pct = 100;
        repeat (20) tick();

        // Asynchronous reset while a read is outstanding and the buffer holds a word.
        do_reset();
        rdy_pct = 0; dly_min = 4; dly_max = 4;
        n = 0;
        tick();
        while (!(instr_valid && pend && !imem_rvalid) && n < 60) begin tick(); n++; end
        if (!(instr_valid && pend && !imem_rvalid)) expire("ar_setup");
        #1 rst_n = 1'b0;
        #1 check_reset_values("ar");
        do_reset();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
